// File: rtl/alu_pkg.sv
// Shared constants for the ARM data-processing ALU and condition logic.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  // Data-processing opcodes, ARM encoding order
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against an NZCV flag vector.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field; NV is treated as never-execute
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_CS:   pass = c;
      CC_CC:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c && !z;
      CC_LS:   pass = !c || z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z && (n == v);
      CC_LE:   pass = z || (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ARM data-processing ALU stage with condition check and NZCV register.
// Latency: 1 cycle from accept to OUT_VALID.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY; outputs hold while stalled.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] OPN,
  input  logic [DW-1:0] OP2,
  input  logic          SFT_COUT,
  input  logic [3:0]    ALU_OP,
  input  logic          S_BIT,
  input  logic [3:0]    COND,
  input  logic [RW-1:0] RD_IN,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] RESULT,
  output logic [RW-1:0] RD_OUT,
  output logic          WB_EN,
  output logic [3:0]    FLAGS
);

  logic          cond_pass;
  logic          accept;
  logic          is_test;
  logic          is_arith;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW:0]   add_sum;
  logic [DW-1:0] logic_res;
  logic [DW-1:0] alu_res;
  logic [3:0]    flags_nxt;
  logic          flag_wr;

  cond_check u_cond_check (
    .cond  (COND),
    .flags (FLAGS),
    .pass  (cond_pass)
  );

  assign IN_READY = !OUT_VALID || OUT_READY;
  assign accept   = IN_VALID && IN_READY && !FLUSH;
  assign is_test  = (ALU_OP == OP_TST) || (ALU_OP == OP_TEQ) ||
                    (ALU_OP == OP_CMP) || (ALU_OP == OP_CMN);
  assign flag_wr  = accept && cond_pass && (S_BIT || is_test);

  // Map every opcode onto one adder: subtraction is a + ~b + cin so carry is NOT borrow
  always_comb begin
    is_arith  = 1'b1;
    add_a     = OPN;
    add_b     = OP2;
    add_cin   = 1'b0;
    logic_res = '0;
    case (ALU_OP)
      OP_SUB, OP_CMP: begin add_b = ~OP2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = OP2; add_b = ~OPN; add_cin = 1'b1; end
      OP_ADD, OP_CMN: add_cin = 1'b0;
      OP_ADC:         add_cin = FLAGS[FLAG_C];
      OP_SBC:         begin add_b = ~OP2; add_cin = FLAGS[FLAG_C]; end
      OP_RSC:         begin add_a = OP2; add_b = ~OPN; add_cin = FLAGS[FLAG_C]; end
      OP_AND, OP_TST: begin is_arith = 1'b0; logic_res = OPN & OP2; end
      OP_EOR, OP_TEQ: begin is_arith = 1'b0; logic_res = OPN ^ OP2; end
      OP_ORR:         begin is_arith = 1'b0; logic_res = OPN | OP2; end
      OP_MOV:         begin is_arith = 1'b0; logic_res = OP2; end
      OP_BIC:         begin is_arith = 1'b0; logic_res = OPN & ~OP2; end
      default:        begin is_arith = 1'b0; logic_res = ~OP2; end
    endcase
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    alu_res = is_arith ? add_sum[DW-1:0] : logic_res;
  end

  // Next NZCV: arithmetic takes adder carry/overflow, logical takes shifter carry and keeps V
  always_comb begin
    flags_nxt         = FLAGS;
    flags_nxt[FLAG_N] = alu_res[DW-1];
    flags_nxt[FLAG_Z] = (alu_res == '0);
    if (is_arith) begin
      flags_nxt[FLAG_C] = add_sum[DW];
      flags_nxt[FLAG_V] = (add_a[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != add_a[DW-1]);
    end else begin
      flags_nxt[FLAG_C] = SFT_COUT;
    end
  end

  // Output register and flag register; flush kills both the held item and any accept
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      RD_OUT    <= '0;
      WB_EN     <= 1'b0;
      FLAGS     <= 4'b0000;
    end else begin
      if (FLUSH) begin
        OUT_VALID <= 1'b0;
      end else if (accept) begin
        OUT_VALID <= 1'b1;
        RESULT    <= alu_res;
        RD_OUT    <= RD_IN;
        WB_EN     <= cond_pass && !is_test;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (flag_wr) begin
        FLAGS <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
// Latency: checks outputs 1 cycle after each accept.
// Backpressure: exercises OUT_READY stalls, FLUSH and mid-stream RST.
module tb_alu_exec_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] OPN;
  logic [31:0] OP2;
  logic        SFT_COUT;
  logic [3:0]  ALU_OP;
  logic        S_BIT;
  logic [3:0]  COND;
  logic [3:0]  RD_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic [3:0]  RD_OUT;
  logic        WB_EN;
  logic [3:0]  FLAGS;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.DW(32), .RW(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OPN       (OPN),
    .OP2       (OP2),
    .SFT_COUT  (SFT_COUT),
    .ALU_OP    (ALU_OP),
    .S_BIT     (S_BIT),
    .COND      (COND),
    .RD_IN     (RD_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .RD_OUT    (RD_OUT),
    .WB_EN     (WB_EN),
    .FLAGS     (FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic [3:0] cc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cout, input logic [3:0] rd);
    ALU_OP   = op;
    S_BIT    = s;
    COND     = cc;
    OPN      = a;
    OP2      = b;
    SFT_COUT = cout;
    RD_IN    = rd;
    IN_VALID = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic s, input logic [3:0] cc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic cout, input logic [3:0] rd);
    drive(op, s, cc, a, b, cout, rd);
    step();
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OPN = '0; OP2 = '0; SFT_COUT = 1'b0; ALU_OP = 4'd0; S_BIT = 1'b0;
    COND = 4'd14; RD_IN = '0;
    step(); step();
    RST = 1'b0;
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_rd", {28'd0, RD_OUT}, 32'd0);
    chk("rst_wb", {31'd0, WB_EN}, 32'd0);
    chk("rst_flags", {28'd0, FLAGS}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);

    // ADDS overflow into sign bit
    send(4'd4, 1'b1, 4'd14, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd1);
    chk("adds_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("adds_result", RESULT, 32'h8000_0000);
    chk("adds_wb", {31'd0, WB_EN}, 32'd1);
    chk("adds_rd", {28'd0, RD_OUT}, 32'd1);
    chk("adds_flags", {28'd0, FLAGS}, 32'b1001);

    // SUBS to zero, then ADDEQ which must pass without touching flags
    send(4'd2, 1'b1, 4'd14, 32'd5, 32'd5, 1'b0, 4'd2);
    chk("subs_result", RESULT, 32'd0);
    chk("subs_flags", {28'd0, FLAGS}, 32'b0110);
    send(4'd4, 1'b0, 4'd0, 32'd1, 32'd1, 1'b0, 4'd3);
    chk("addeq_result", RESULT, 32'd2);
    chk("addeq_wb", {31'd0, WB_EN}, 32'd1);
    chk("addeq_flags", {28'd0, FLAGS}, 32'b0110);

    // CMP without S bit still writes flags; MOVGE then fails (N!=V)
    send(4'd10, 1'b0, 4'd14, 32'd3, 32'd4, 1'b0, 4'd1);
    chk("cmp_flags", {28'd0, FLAGS}, 32'b1000);
    chk("cmp_wb", {31'd0, WB_EN}, 32'd0);
    chk("cmp_result", RESULT, 32'hFFFF_FFFF);
    send(4'd13, 1'b1, 4'd10, 32'd0, 32'd7, 1'b0, 4'd2);
    chk("movge_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("movge_wb", {31'd0, WB_EN}, 32'd0);
    chk("movge_rd", {28'd0, RD_OUT}, 32'd2);
    chk("movge_flags", {28'd0, FLAGS}, 32'b1000);

    // Set V, then ANDS keeps V and takes C from the shifter
    send(4'd4, 1'b1, 4'd14, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd1);
    chk("vset_flags", {28'd0, FLAGS}, 32'b1001);
    send(4'd0, 1'b1, 4'd14, 32'hF0, 32'h0F, 1'b1, 4'd3);
    chk("ands_result", RESULT, 32'd0);
    chk("ands_flags", {28'd0, FLAGS}, 32'b0111);

    // ADCS consumes C=1: 1+2+1
    send(4'd5, 1'b1, 4'd14, 32'd1, 32'd2, 1'b0, 4'd4);
    chk("adcs_result", RESULT, 32'd4);
    chk("adcs_flags", {28'd0, FLAGS}, 32'b0000);

    // RSBS: 10 - 3
    send(4'd3, 1'b1, 4'd14, 32'd3, 32'd10, 1'b0, 4'd5);
    chk("rsbs_result", RESULT, 32'd7);
    chk("rsbs_flags", {28'd0, FLAGS}, 32'b0010);

    // NV never executes even with S set
    send(4'd13, 1'b1, 4'd15, 32'd0, 32'd0, 1'b1, 4'd6);
    chk("nv_wb", {31'd0, WB_EN}, 32'd0);
    chk("nv_flags", {28'd0, FLAGS}, 32'b0010);

    // Backpressure: hold item 0x44 while 0x55 waits upstream
    send(4'd13, 1'b0, 4'd14, 32'd0, 32'h44, 1'b0, 4'd4);
    OUT_READY = 1'b0;
    drive(4'd13, 1'b0, 4'd14, 32'd0, 32'h55, 1'b0, 4'd5);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, IN_READY}, 32'd0);
      chk("stall_result", RESULT, 32'h44);
      chk("stall_rd", {28'd0, RD_OUT}, 32'd4);
      chk("stall_valid", {31'd0, OUT_VALID}, 32'd1);
      step();
    end
    OUT_READY = 1'b1;
    #1;
    chk("unstall_in_ready", {31'd0, IN_READY}, 32'd1);
    step();
    IN_VALID = 1'b0;
    chk("unstall_result", RESULT, 32'h55);
    chk("unstall_rd", {28'd0, RD_OUT}, 32'd5);
    chk("unstall_valid", {31'd0, OUT_VALID}, 32'd1);

    // FLUSH with a held item and a would-be accept of ADDS 1+1
    drive(4'd4, 1'b1, 4'd14, 32'd1, 32'd1, 1'b0, 4'd6);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    chk("flush_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("flush_flags", {28'd0, FLAGS}, 32'b0010);
    chk("flush_result", RESULT, 32'h55);

    // RST mid-stream overrides a pending accept
    send(4'd4, 1'b1, 4'd14, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd7);
    chk("pre_rst_flags", {28'd0, FLAGS}, 32'b1001);
    drive(4'd4, 1'b1, 4'd14, 32'd2, 32'd3, 1'b0, 4'd8);
    RST = 1'b1;
    step();
    RST = 1'b0;
    IN_VALID = 1'b0;
    chk("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("mid_rst_result", RESULT, 32'd0);
    chk("mid_rst_rd", {28'd0, RD_OUT}, 32'd0);
    chk("mid_rst_wb", {31'd0, WB_EN}, 32'd0);
    chk("mid_rst_flags", {28'd0, FLAGS}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
